// File: rtl/rca_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    function automatic int nibbles_of(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Operand/result valid-ready bundle for rca_seq_ctrl.
// Optional RCA_SEQ_SUB_EN adds the sub request bit.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef RCA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef RCA_SEQ_SUB_EN
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/rca_seq_ctrl_rca.sv
// Existing 4-bit ripple-carry adder reused by the sequencer, one nibble per cycle.
module ripple_carry_adder
    import rca_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIB_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit adder sequencer: one nibble per clock through a shared 4-bit RCA.
// Optional RCA_SEQ_SUB_EN adds a subtract request (a - b via inverted B and carry-in 1).
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rca_seq_ctrl_if.slave bus
);

    localparam int NIBBLES = nibbles_of(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDX_W-1:0] r_idx;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_last;
    logic             w_cin0;
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_raw;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_rca_sum;
    logic             w_rca_cout;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
    assign w_b_raw = r_b[r_idx*NIB_W +: NIB_W];

`ifdef RCA_SEQ_SUB_EN
    logic r_sub;

    // Subtract is a + ~b + 1: invert each B nibble and seed the chain with 1.
    assign w_cin0  = bus.sub ? 1'b1 : bus.cin;
    assign w_b_nib = r_sub ? ~w_b_raw : w_b_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_sub <= bus.sub;
        end
    end
`else
    assign w_cin0  = bus.cin;
    assign w_b_nib = w_b_raw;
`endif

    ripple_carry_adder u_rca (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_rca_sum),
        .cout (w_rca_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = ADD;
            ADD:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: w_in_ready = 1'b1;
            ADD:  w_busy     = 1'b1;
            DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands are captured only at the accept; the sum is cleared there so a
    // fresh result never mixes with nibbles of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= w_cin0;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                ADD: begin
                    r_sum[r_idx*NIB_W +: NIB_W] <= w_rca_sum;
                    r_carry                     <= w_rca_cout;
                    if (w_last) begin
                        r_cout <= w_rca_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed cases plus randomized traffic against a cycle model.
module tb_rca_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst_n;

    rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: idle / counting cycles since accept / result presented.
    logic             m_idle;
    int               m_cnt;
    logic [WIDTH:0]   m_pend;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ov;

    assign m_ov = !m_idle && (m_cnt == NIB);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_cnt  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_pend <= '0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
`ifdef RCA_SEQ_SUB_EN
                if (bus.sub)
                    m_pend <= {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
                else
`endif
                m_pend <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                m_idle <= 1'b0;
                m_cnt  <= 0;
                m_sum  <= '0;
            end
        end else if (m_cnt < NIB) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == NIB - 1) begin
                m_sum  <= m_pend[WIDTH-1:0];
                m_cout <= m_pend[WIDTH];
            end
        end else if (bus.out_ready) begin
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_idle));
            chk("busy",      32'(bus.busy),      32'(!m_idle));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_idle || m_ov) begin
                chk("sum",  32'(bus.sum),  32'(m_sum));
                chk("cout", 32'(bus.cout), 32'(m_cout));
            end
        end
    end

    // Present operands, wait for acceptance, then scramble the inputs.
    task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            ok = bus.in_ready;
        end
        if (!ok) begin
            chk("accept_timeout", 32'(ok), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.cin      = 1'($urandom);
        end
    endtask

    // Called #1 after the accept edge: checks latency, optional literal result, holds, then drains.
    task automatic get_result(input int hold, input bit lit, input logic [WIDTH-1:0] es, input logic ec);
        logic             seen;
        int               k;
        logic [WIDTH-1:0] s0;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            seen = bus.out_valid;
        end
        if (!seen) begin
            chk("result_timeout", 32'(seen), 32'd1);
            return;
        end
        chk("latency", 32'(k), 32'(NIB));
        if (lit) begin
            chk("lit_sum",  32'(bus.sum),  32'(es));
            chk("lit_cout", 32'(bus.cout), 32'(ec));
        end
        s0 = bus.sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_sum",      32'(bus.sum),       32'(s0));
            chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
            chk("hold_valid",    32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        accept_op(16'h1234, 16'h4321, 1'b0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        get_result(0, 1'b1, 16'h5555, 1'b0);

        accept_op(16'hFFFF, 16'h0001, 1'b0);
        get_result(1, 1'b1, 16'h0000, 1'b1);
        accept_op(16'hFFFF, 16'hFFFF, 1'b1);
        get_result(0, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure with a competing request that must wait for the drain.
        accept_op(16'h0F0F, 16'h0101, 1'b0);
        begin
            int k;
            k = 0;
            while (!bus.out_valid && k < 40) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("t3_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_sum",   32'(bus.sum),       32'h1010);
            bus.a        = 16'h0001;
            bus.b        = 16'h0002;
            bus.cin      = 1'b0;
            bus.in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("t3_hold_sum",   32'(bus.sum),       32'h1010);
                chk("t3_in_ready",   32'(bus.in_ready),  32'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk("t3_idle_ready", 32'(bus.in_ready), 32'd1);
            chk("t3_idle_busy",  32'(bus.busy),     32'd0);
            @(posedge clk);
            #1;
            chk("t3_accepted", 32'(bus.busy), 32'd1);
            bus.in_valid = 1'b0;
            bus.a        = 16'hDEAD;
            get_result(0, 1'b1, 16'h0003, 1'b0);
        end

        // Reset while the third nibble is being added.
        accept_op(16'hABCD, 16'h1111, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_busy",      32'(bus.busy),      32'd0);
        chk("t5_sum",       32'(bus.sum),       32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept_op(16'h00FF, 16'h0001, 1'b0);
        get_result(0, 1'b1, 16'h0100, 1'b0);

`ifdef RCA_SEQ_SUB_EN
        bus.sub = 1'b1;
        accept_op(16'h0005, 16'h0007, 1'b0);
        bus.sub = 1'b0;
        get_result(0, 1'b1, 16'hFFFE, 1'b0);
        bus.sub = 1'b1;
        accept_op(16'h0007, 16'h0005, 1'b0);
        bus.sub = 1'b0;
        get_result(0, 1'b1, 16'h0002, 1'b1);
`endif

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            if (n % 8 == 0) ra = '1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
`ifdef RCA_SEQ_SUB_EN
            bus.sub = 1'($urandom);
`endif
            accept_op(ra, rb, rc);
            get_result(int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Sequencer that runs WIDTH-bit additions on one shared 4-bit ripple_carry_adder.
- Processes one nibble per clock, least significant first, and holds the carry in a register between nibbles.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Lets wide adds reuse the existing 4-bit RCA instead of building a wide combinational adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to the least significant nibble.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the most significant nibble.
- busy  output  1  an operation is in progress (state ADD or DONE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, nibble index idx=0, carry_q=0.
  - a_q, b_q, sum_q all 0; cout_q=0.
  - out_valid=0, busy=0.
  - in_ready=1, because it is decoded from IDLE; it is 1 while reset is held.
- States are IDLE, ADD and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q<=a, b_q<=b, carry_q<=cin, idx<=0, sum_q<=0, then go to ADD.
  - Operands are sampled only at this handshake; later changes on a/b/cin are ignored.
- ADD:
  - The RCA inputs are a_q[4*idx+:4], b_q[4*idx+:4] and carry_q.
  - Each cycle: sum_q[4*idx+:4]<=rca.sum, carry_q<=rca.cout, idx<=idx+1.
  - When idx==NIBBLES-1: cout_q<=rca.cout, idx<=0, go to DONE.
  - in_ready=0 throughout ADD.
- DONE:
  - out_valid=1; sum=sum_q and cout=cout_q are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
  - in_ready=0 in DONE; no overlap with the next request.
- Latency: accept at edge N, out_valid high after edge N+NIBBLES (WIDTH=16: 4 cycles). Minimum issue interval is NIBBLES+2 cycles.
- sum and cout are registered. sum reads 0 in IDLE after reset; otherwise it holds the last result until the next accept clears it.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- idx has width $clog2(NIBBLES) and never exceeds NIBBLES-1.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; in_valid is served the following cycle in IDLE.
- Reset mid-operation aborts the operation and discards partial results. No out_valid is produced for the aborted request.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at the accept handshake.
  - With sub=1, every B nibble is inverted before the RCA and the initial carry_q is 1; cin is ignored.
  - Result = a - b modulo 2^WIDTH; cout=1 means no borrow (a>=b, unsigned).
  - With sub=0, behaviour is identical to the base block.
- When undefined: no sub port and no inversion logic.

Decomposition:
- Package rca_seq_pkg holds:
  - the state enum typedef (IDLE, ADD, DONE);
  - the constant NIB_W=4;
  - a function returning nibble count from WIDTH.
- Sub-module: one instance of the existing ripple_carry_adder (a, b, cin, sum, cout). The controller contains only sequencing and storage.

Test Plan (WIDTH=16):
1. a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid rises exactly 4 cycles after accept; busy=1 throughout.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry chains through all 4 nibbles). Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
3. Backpressure: result ready, out_ready held 0 for 5 cycles -> out_valid=1 and sum/cout stable; in_ready=0; new in_valid ignored until the result handshake plus one cycle.
4. Operand change after accept: a changed on the cycle after the handshake -> result uses the latched a.
5. rst_n pulsed low during ADD at idx=2 -> state IDLE, out_valid=0, sum=0, in_ready=1; next request a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
6. RCA_SEQ_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
